pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 28 ++
 rtl/pong_game_ctrl_if.sv | 28 ++
 rtl/pong_timer.sv | 35 +++
 rtl/pong_game_ctrl.sv | 128 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: state/winner encodings and field widths used by the
// game controller, pong_graph and the text overlay.
package pong_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned RALLY_W = 8;
    localparam int unsigned WIN_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_e;

    typedef enum logic [WIN_W-1:0] {
        WIN_NONE = 2'd0,
        WIN_L    = 2'd1,
        WIN_R    = 2'd2
    } winner_e;

    // Rally counter increment that sticks at all-ones.
    function automatic logic [RALLY_W-1:0] sat_inc(input logic [RALLY_W-1:0] v);
        return (v == '1) ? v : v + RALLY_W'(1);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Event inputs and score/state outputs exchanged between the game controller
// and its surroundings (buttons, VGA timing, pong_graph, overlay).
interface pong_game_ctrl_if;
    import pong_pkg::*;

    logic               btn_start;
    logic               frame_tick;
    logic               hit;
    logic               miss_l;
    logic               miss_r;
    logic               gra_still;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic [RALLY_W-1:0] rally;
    logic [WIN_W-1:0]   winner;
    logic [STATE_W-1:0] state;

    modport master (
        output btn_start, frame_tick, hit, miss_l, miss_r,
        input  gra_still, score_l, score_r, rally, winner, state
    );

    modport slave (
        input  btn_start, frame_tick, hit, miss_l, miss_r,
        output gra_still, score_l, score_r, rally, winner, state
    );

endinterface

// File: rtl/pong_timer.sv
// Loadable down-counter for the serve/game-over pause; counts frame ticks,
// holds at zero, and flags the tick that arrives while already at zero.
module pong_timer #(
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned LOAD_VAL = 120
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic tick_i,
    output logic done_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = WIDTH'(LOAD_VAL);
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = tick_i && (count_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: start, serve pauses, scoring, rally count and winner.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned TIMER_TICKS = 120,
    parameter int unsigned WIN_SCORE   = 9
) (
    input  logic              clk,
    input  logic              reset,
    pong_game_ctrl_if.slave   bus
);

    localparam int unsigned TIMER_W = (TIMER_TICKS > 0) ? $clog2(TIMER_TICKS + 1) : 1;

    state_e             state_q, state_d;
    winner_e            winner_q, winner_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic [RALLY_W-1:0] rally_q, rally_d;
    logic               start_prev_q;
    logic [SCORE_W-1:0] new_l, new_r;
    logic               start_rise;
    logic               pausing;
    logic               timer_load;
    logic               timer_done;

    assign start_rise = bus.btn_start & ~start_prev_q;
    assign pausing    = (state_q == NEWBALL) || (state_q == OVER);

    pong_timer #(
        .WIDTH    (TIMER_W),
        .LOAD_VAL (TIMER_TICKS)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (timer_load),
        .tick_i (bus.frame_tick & pausing),
        .done_o (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        rally_d    = rally_q;
        timer_load = 1'b0;
        new_l      = score_l_q + SCORE_W'(1);
        new_r      = score_r_q + SCORE_W'(1);

        case (state_q)
            NEWGAME: begin
                score_l_d = '0;
                score_r_d = '0;
                rally_d   = '0;
                winner_d  = WIN_NONE;
                if (start_rise) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // A miss ends the rally and overrides any simultaneous hit.
                if (bus.miss_l || bus.miss_r) begin
                    rally_d    = '0;
                    timer_load = 1'b1;
                    state_d    = NEWBALL;
                    if (bus.miss_l && !bus.miss_r) begin
                        score_r_d = new_r;
                        if (new_r == SCORE_W'(WIN_SCORE)) begin
                            state_d  = OVER;
                            winner_d = WIN_R;
                        end
                    end else if (bus.miss_r && !bus.miss_l) begin
                        score_l_d = new_l;
                        if (new_l == SCORE_W'(WIN_SCORE)) begin
                            state_d  = OVER;
                            winner_d = WIN_L;
                        end
                    end
                end else if (bus.hit) begin
                    rally_d = sat_inc(rally_q);
                end
            end
            NEWBALL: begin
                if (timer_done) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (timer_done) begin
                    state_d   = NEWGAME;
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = WIN_NONE;
                end
            end
            default: begin
                state_d = NEWGAME;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= NEWGAME;
            winner_q     <= WIN_NONE;
            score_l_q    <= '0;
            score_r_q    <= '0;
            rally_q      <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            rally_q      <= rally_d;
            start_prev_q <= bus.btn_start;
        end
    end

    assign bus.gra_still = (state_q != PLAY);
    assign bus.state     = state_q;
    assign bus.score_l   = score_l_q;
    assign bus.score_r   = score_r_q;
    assign bus.rally     = rally_q;
    assign bus.winner    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed match scenarios plus random play, checked
// every cycle against an integer game model.
module tb_pong_game_ctrl;

    localparam int unsigned T_TICKS = 3;
    localparam int unsigned W_SCORE = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pong_game_ctrl_if bus_if ();

    pong_game_ctrl #(
        .TIMER_TICKS (T_TICKS),
        .WIN_SCORE   (W_SCORE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Game model: 0 new game, 1 play, 2 serve pause, 3 game over
    int m_state, m_sl, m_sr, m_rally, m_win, m_timer;
    bit m_prev;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit rise;
        if (reset) begin
            m_state = 0; m_sl = 0; m_sr = 0; m_rally = 0; m_win = 0; m_timer = 0; m_prev = 0;
        end else begin
            rise   = bus_if.btn_start && !m_prev;
            m_prev = bus_if.btn_start;
            if (m_state == 0) begin
                if (rise) m_state = 1;
            end else if (m_state == 1) begin
                if (bus_if.miss_l || bus_if.miss_r) begin
                    m_rally = 0;
                    m_timer = T_TICKS;
                    m_state = 2;
                    if (bus_if.miss_l && !bus_if.miss_r) begin
                        m_sr++;
                        if (m_sr == W_SCORE) begin m_state = 3; m_win = 2; end
                    end else if (bus_if.miss_r && !bus_if.miss_l) begin
                        m_sl++;
                        if (m_sl == W_SCORE) begin m_state = 3; m_win = 1; end
                    end
                end else if (bus_if.hit && m_rally < 255) begin
                    m_rally++;
                end
            end else if (bus_if.frame_tick) begin
                if (m_timer > 0) m_timer--;
                else if (m_state == 2) m_state = 1;
                else begin m_state = 0; m_sl = 0; m_sr = 0; m_win = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",     int'(bus_if.state),     m_state);
            chk("gra_still", int'(bus_if.gra_still), (m_state != 1) ? 1 : 0);
            chk("score_l",   int'(bus_if.score_l),   m_sl);
            chk("score_r",   int'(bus_if.score_r),   m_sr);
            chk("rally",     int'(bus_if.rally),     m_rally);
            chk("winner",    int'(bus_if.winner),    m_win);
            chk("timer",     int'(dut.u_timer.count_q), m_timer);
        end
    end

    // Apply one cycle of inputs at a falling edge, return at the next one.
    task automatic drive(input bit b, input bit ft, input bit h, input bit ml, input bit mr);
        bus_if.btn_start  = b;
        bus_if.frame_tick = ft;
        bus_if.hit        = h;
        bus_if.miss_l     = ml;
        bus_if.miss_r     = mr;
        @(negedge clk);
    endtask

    initial begin
        int rises;
        int ps;
        bit btn;

        reset = 1'b1;
        bus_if.btn_start = 0; bus_if.frame_tick = 0; bus_if.hit = 0;
        bus_if.miss_l = 0; bus_if.miss_r = 0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_state", int'(bus_if.state), 0);
        chk("reset_still", int'(bus_if.gra_still), 1);
        reset = 1'b0;

        // Held start button yields a single start event
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            ps = int'(bus_if.state);
            drive(1, 0, 0, 0, 0);
            if (ps == 0 && int'(bus_if.state) == 1) rises++;
            if (i == 0) chk("still_after_start", int'(bus_if.gra_still), 0);
        end
        chk("start_events", rises, 1);
        chk("start_play", int'(bus_if.state), 1);

        // Right miss scores left, pause lasts T_TICKS+1 frame ticks
        drive(0, 0, 0, 0, 1);
        chk("miss_r_sl", int'(bus_if.score_l), 1);
        chk("miss_r_state", int'(bus_if.state), 2);
        chk("miss_r_still", int'(bus_if.gra_still), 1);
        repeat (3) drive(0, 1, 0, 0, 0);
        chk("pause_3ticks", int'(bus_if.state), 2);
        drive(0, 1, 0, 0, 0);
        chk("pause_done", int'(bus_if.state), 1);
        chk("pause_sl", int'(bus_if.score_l), 1);

        // Right player reaches WIN_SCORE
        drive(0, 0, 0, 1, 0);
        chk("miss_l1_sr", int'(bus_if.score_r), 1);
        repeat (4) drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        chk("win_sr", int'(bus_if.score_r), 2);
        chk("win_code", int'(bus_if.winner), 2);
        chk("win_state", int'(bus_if.state), 3);
        repeat (3) drive(0, 1, 0, 0, 0);
        chk("over_hold", int'(bus_if.state), 3);
        drive(0, 1, 0, 0, 0);
        chk("over_newgame", int'(bus_if.state), 0);
        chk("over_sl", int'(bus_if.score_l), 0);
        chk("over_sr", int'(bus_if.score_r), 0);
        chk("over_win", int'(bus_if.winner), 0);

        // Rally saturation
        drive(1, 0, 0, 0, 0);
        chk("restart", int'(bus_if.state), 1);
        repeat (300) drive(0, 0, 1, 0, 0);
        chk("rally_sat", int'(bus_if.rally), 255);
        drive(0, 0, 1, 1, 0);
        chk("rally_clr", int'(bus_if.rally), 0);
        chk("rally_clr_sr", int'(bus_if.score_r), 1);
        drive(0, 0, 1, 0, 0);
        chk("hit_in_pause", int'(bus_if.rally), 0);
        repeat (4) drive(0, 1, 0, 0, 0);
        chk("serve2", int'(bus_if.state), 1);

        // Double miss: no score, still a serve pause
        drive(0, 0, 0, 1, 1);
        chk("dbl_sl", int'(bus_if.score_l), 0);
        chk("dbl_sr", int'(bus_if.score_r), 1);
        chk("dbl_state", int'(bus_if.state), 2);
        drive(0, 0, 1, 0, 0);
        chk("dbl_hit", int'(bus_if.rally), 0);
        repeat (4) drive(0, 1, 0, 0, 0);
        chk("serve3", int'(bus_if.state), 1);

        // Reset in the middle of a pause
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0);
        chk("mid_timer", int'(dut.u_timer.count_q), 2);
        chk("mid_sl", int'(bus_if.score_l), 1);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        chk("rst_state", int'(bus_if.state), 0);
        chk("rst_sl", int'(bus_if.score_l), 0);
        chk("rst_sr", int'(bus_if.score_r), 0);
        chk("rst_timer", int'(dut.u_timer.count_q), 0);
        chk("rst_still", int'(bus_if.gra_still), 1);

        // Random play against the model
        btn = 1'b0;
        repeat (4000) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) btn = ~btn;
            drive(btn,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0);
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
